player_action_ctrl: RTL and testbench
=====================================

# player_action_ctrl

Per-player action controller that turns debounced button levels into the 7-bit action word consumed by the player sprite block, plus the player's horizontal position. It runs a six-state fighter FSM advanced on a game-tick strobe, timing jumps and punches and saturating movement to the arena bounds. One instance per player sits between the input debouncers and the sprite/renderer logic.

## Interface
- PUNCH_TICKS, 8: ticks spent in PUNCHING per punch (≥1)
- JUMP_TICKS, 16: ticks spent in JUMPING per jump (≥1)
- WALK_STEP, 2: pixels moved per tick while walking or drifting in a jump
- X_MIN, 0 / X_MAX, 511: inclusive position bounds
- X_INIT, 100: position after reset
- INIT_DIR, 0: facing after reset (0 = right, 1 = left/mirrored)
- clk  in  1  system clock
- rst_l  in  1  asynchronous, active-low reset
- tick  in  1  one-cycle game-tick strobe; all state updates happen only on cycles with tick=1
- btn_left, btn_right, btn_up, btn_down, btn_shield, btn_punch  in  1 each  debounced button levels
- action  out  7  [6] = facing (1 = mirrored), [5:0] one-hot: WALKING 000001, CROUCHING 000010, SHIELDING 000100, JUMPING 001000, PUNCHING 010000, STANDING 100000
- x_pos  out  10  player x position
- punch_hit  out  1  one-clk pulse on punch start
- busy  out  1  high while in JUMPING or PUNCHING

## Operation
- States: STAND, WALK, CROUCH, SHIELD (free states); JUMP, PUNCH (timed states). action[5:0] is the one-hot code of the current state.
- Edge detect: up_prev, punch_prev sampled on every tick in every state; up_edge = btn_up & ~up_prev, punch_edge likewise. Holding a button never retriggers.
- From a free state, next state on tick by priority: punch_edge → PUNCH; up_edge → JUMP; btn_shield → SHIELD; btn_down → CROUCH; exactly one of left/right → WALK; else STAND (left+right together = STAND).
- WALK tick: facing ← 1 for left, 0 for right; x_pos ± WALK_STEP, saturating at X_MIN/X_MAX. Movement applies on the tick that enters or stays in WALK.
- JUMP entry: timer ← JUMP_TICKS−1; jump_dx latched as −1/0/+1 from left/right (both/neither = 0); facing unchanged. Each JUMP tick: x_pos += jump_dx·WALK_STEP saturating; if timer=0 → STAND, else timer−1. Buttons other than edge sampling ignored.
- PUNCH entry: timer ← PUNCH_TICKS−1, punch_hit=1 for that one clk. No movement, facing frozen. Timer=0 on a tick → STAND.
- Timed states always exit to STAND; new action chosen no earlier than the following tick.
- Saturation computed in ≥11-bit signed arithmetic; x_pos never leaves [X_MIN, X_MAX].

## Timing
- All outputs registered; updated on the clk edge where tick=1, visible the following cycle. tick=0 cycles: no output or state change, punch_hit=0.
- Reset values (asynchronous): state STAND, action = {INIT_DIR, 6'b100000}, x_pos = X_INIT, timer 0, up_prev/punch_prev 0, jump_dx 0, punch_hit 0, busy 0.
- JUMPING visible for exactly JUMP_TICKS ticks, PUNCHING for PUNCH_TICKS ticks, then STANDING for ≥1 tick.
- busy asserted on the same edge as JUMPING/PUNCHING appears, deasserted with STANDING.
- Reset mid-jump or mid-punch: immediate return to reset values; a button already held at release needs a fresh edge (prev regs cleared, so held up/punch yields an edge on the first tick after reset).

## Test plan
- Reset: after rst_l release with all buttons low, action=7'b0100000, x_pos=100, busy=0, punch_hit=0; tick pulses keep it unchanged.
- Walk: hold right 5 ticks → action=7'b0000001, x_pos=110; then left 1 tick → action=7'b1000001, x_pos=108; left+right → 7'b1100000, x_pos held.
- Saturation: hold left 60 ticks from 100 → x_pos reaches 0 after 50 ticks and stays 0; no wrap to 1023.
- Punch: hold punch 20 ticks → PUNCHING (7'bx010000) for 8 ticks, punch_hit high exactly 1 clk, then STANDING; no second punch until release and re-press.
- Jump: up edge with right held → JUMPING 16 ticks, x_pos +32, busy high throughout, then STANDING one tick; rst_l pulse at tick 5 of a jump → action=7'b0100000, x_pos=100 immediately.
- Priority: punch and up edges same tick → PUNCHING; shield+down → SHIELDING; down alone → CROUCHING; no change on cycles with tick=0.

Source files
------------

// File: rtl/player_action_ctrl.sv
// Per-player fighter FSM. Turns debounced button levels into a one-hot action word
// with a facing bit, and tracks horizontal position. All updates happen on tick.
module player_action_ctrl #(
  parameter int PUNCH_TICKS = 8,
  parameter int JUMP_TICKS  = 16,
  parameter int WALK_STEP   = 2,
  parameter int X_MIN       = 0,
  parameter int X_MAX       = 511,
  parameter int X_INIT      = 100,
  parameter int INIT_DIR    = 0
) (
  input  logic       clk,
  input  logic       rst_l,
  input  logic       tick,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_shield,
  input  logic       btn_punch,
  output logic [6:0] action,
  output logic [9:0] x_pos,
  output logic       punch_hit,
  output logic       busy
);

  // The state register holds the one-hot action code, so action[5:0] needs no decode.
  localparam logic [5:0] S_WALK   = 6'b000001;
  localparam logic [5:0] S_CROUCH = 6'b000010;
  localparam logic [5:0] S_SHIELD = 6'b000100;
  localparam logic [5:0] S_JUMP   = 6'b001000;
  localparam logic [5:0] S_PUNCH  = 6'b010000;
  localparam logic [5:0] S_STAND  = 6'b100000;

  localparam int TMAX = (JUMP_TICKS > PUNCH_TICKS) ? JUMP_TICKS : PUNCH_TICKS;
  localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;

  localparam logic signed [11:0] XMIN_S = 12'(X_MIN);
  localparam logic signed [11:0] XMAX_S = 12'(X_MAX);
  localparam logic signed [11:0] STEP_S = 12'(WALK_STEP);

  logic [5:0]        state, state_n;
  logic              facing, facing_n;
  logic [TW-1:0]     timer, timer_n;
  logic signed [1:0] jump_dx, jump_dx_n;
  logic [9:0]        x_n;
  logic              hit_n;
  logic              up_prev, punch_prev;
  logic              up_edge, punch_edge;
  logic signed [11:0] x_ext;

  function automatic logic [9:0] sat_x(input logic signed [11:0] v);
    logic signed [11:0] r;
    if (v < XMIN_S)      r = XMIN_S;
    else if (v > XMAX_S) r = XMAX_S;
    else                 r = v;
    return r[9:0];
  endfunction

  assign up_edge    = btn_up & ~up_prev;
  assign punch_edge = btn_punch & ~punch_prev;
  assign x_ext      = $signed({2'b00, x_pos});

  always_comb begin
    state_n   = state;
    facing_n  = facing;
    timer_n   = timer;
    jump_dx_n = jump_dx;
    x_n       = x_pos;
    hit_n     = 1'b0;
    if (state == S_JUMP) begin
      if (jump_dx > 0)      x_n = sat_x(x_ext + STEP_S);
      else if (jump_dx < 0) x_n = sat_x(x_ext - STEP_S);
      if (timer == '0) state_n = S_STAND;
      else             timer_n = timer - 1'b1;
    end else if (state == S_PUNCH) begin
      if (timer == '0) state_n = S_STAND;
      else             timer_n = timer - 1'b1;
    end else if (punch_edge) begin
      state_n = S_PUNCH;
      timer_n = TW'(PUNCH_TICKS - 1);
      hit_n   = 1'b1;
    end else if (up_edge) begin
      state_n   = S_JUMP;
      timer_n   = TW'(JUMP_TICKS - 1);
      jump_dx_n = (btn_left == btn_right) ? 2'sd0 : (btn_left ? -2'sd1 : 2'sd1);
    end else if (btn_shield) begin
      state_n = S_SHIELD;
    end else if (btn_down) begin
      state_n = S_CROUCH;
    end else if (btn_left ^ btn_right) begin
      state_n  = S_WALK;
      facing_n = btn_left;
      x_n      = btn_left ? sat_x(x_ext - STEP_S) : sat_x(x_ext + STEP_S);
    end else begin
      state_n = S_STAND;
    end
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      state      <= S_STAND;
      facing     <= (INIT_DIR != 0);
      x_pos      <= 10'(X_INIT);
      timer      <= '0;
      jump_dx    <= 2'sd0;
      up_prev    <= 1'b0;
      punch_prev <= 1'b0;
      punch_hit  <= 1'b0;
      busy       <= 1'b0;
    end else begin
      punch_hit <= 1'b0;
      if (tick) begin
        state      <= state_n;
        facing     <= facing_n;
        x_pos      <= x_n;
        timer      <= timer_n;
        jump_dx    <= jump_dx_n;
        up_prev    <= btn_up;
        punch_prev <= btn_punch;
        punch_hit  <= hit_n;
        busy       <= (state_n == S_JUMP) || (state_n == S_PUNCH);
      end
    end
  end

  assign action = {facing, state};

endmodule

// File: tb/tb_player_action_ctrl.sv
// Bench for player_action_ctrl: directed scenarios plus random button/tick traffic,
// compared every cycle against a behavioural model counting remaining ticks per move.
module tb_player_action_ctrl;

  localparam int PUNCH_TICKS = 8;
  localparam int JUMP_TICKS  = 16;
  localparam int WALK_STEP   = 2;
  localparam int X_MIN       = 0;
  localparam int X_MAX       = 511;
  localparam int X_INIT      = 100;

  // mode numbers equal the bit position of the action one-hot code
  localparam int M_WALK = 0, M_CROUCH = 1, M_SHIELD = 2, M_JUMP = 3, M_PUNCH = 4, M_STAND = 5;

  logic clk = 1'b0, rst_l = 1'b0, tick = 1'b0;
  logic btn_left = 0, btn_right = 0, btn_up = 0, btn_down = 0, btn_shield = 0, btn_punch = 0;
  logic [6:0] action;
  logic [9:0] x_pos;
  logic       punch_hit, busy;

  int n_cmp = 0, n_err = 0;
  int m_mode, m_rem, m_dx, m_x, m_hit_cnt;
  bit m_face, m_hit, m_up_p, m_pu_p;

  player_action_ctrl dut (
    .clk(clk), .rst_l(rst_l), .tick(tick),
    .btn_left(btn_left), .btn_right(btn_right), .btn_up(btn_up),
    .btn_down(btn_down), .btn_shield(btn_shield), .btn_punch(btn_punch),
    .action(action), .x_pos(x_pos), .punch_hit(punch_hit), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int clamp(input int v);
    return (v < X_MIN) ? X_MIN : ((v > X_MAX) ? X_MAX : v);
  endfunction

  function automatic logic [6:0] exp_action();
    logic [5:0] oh;
    oh = 6'b1 << m_mode;
    return {m_face, oh};
  endfunction

  task automatic model_reset();
    m_mode = M_STAND; m_rem = 0; m_dx = 0; m_x = X_INIT;
    m_face = 0; m_hit = 0; m_up_p = 0; m_pu_p = 0;
  endtask

  task automatic model_tick();
    bit ue, pe;
    ue = btn_up && !m_up_p;
    pe = btn_punch && !m_pu_p;
    m_up_p = btn_up;
    m_pu_p = btn_punch;
    m_hit = 0;
    if (m_mode == M_JUMP) begin
      m_x = clamp(m_x + m_dx * WALK_STEP);
      m_rem--;
      if (m_rem == 0) m_mode = M_STAND;
    end else if (m_mode == M_PUNCH) begin
      m_rem--;
      if (m_rem == 0) m_mode = M_STAND;
    end else if (pe) begin
      m_mode = M_PUNCH; m_rem = PUNCH_TICKS; m_hit = 1;
    end else if (ue) begin
      m_mode = M_JUMP; m_rem = JUMP_TICKS;
      m_dx = int'(btn_right) - int'(btn_left);
    end else if (btn_shield) m_mode = M_SHIELD;
    else if (btn_down)       m_mode = M_CROUCH;
    else if (btn_left != btn_right) begin
      m_mode = M_WALK;
      m_face = btn_left;
      m_x = clamp(m_x + (btn_left ? -WALK_STEP : WALK_STEP));
    end else m_mode = M_STAND;
  endtask

  task automatic check_all();
    check("action", 32'(action), 32'(exp_action()));
    check("x_pos", 32'(x_pos), 32'(m_x));
    check("punch_hit", 32'(punch_hit), 32'(m_hit));
    check("busy", 32'(busy), 32'(m_mode == M_JUMP || m_mode == M_PUNCH));
  endtask

  // one clock; inputs already set away from the edge, outputs sampled 1 ns after it
  task automatic step(input bit t);
    tick = t;
    @(posedge clk);
    if (t) model_tick();
    else m_hit = 0;
    #1;
    if (punch_hit) m_hit_cnt++;
    check_all();
  endtask

  task automatic set_btn(input bit l, r, u, d, s, p);
    btn_left = l; btn_right = r; btn_up = u; btn_down = d; btn_shield = s; btn_punch = p;
  endtask

  task automatic do_reset();
    rst_l = 1'b0;
    #2;
    model_reset();
    check("rst_action", 32'(action), 32'h20);
    check("rst_x", 32'(x_pos), 32'd100);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_hit", 32'(punch_hit), 32'd0);
    #1 rst_l = 1'b1;
  endtask

  initial begin
    set_btn(0, 0, 0, 0, 0, 0);
    @(posedge clk); #1;
    do_reset();
    for (int i = 0; i < 4; i++) step(i[0]);
    check("idle_action", 32'(action), 32'h20);

    // walking
    set_btn(0, 1, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin step(1); step(0); end
    check("walk_r_act", 32'(action), 32'b0000001);
    check("walk_r_x", 32'(x_pos), 32'd110);
    set_btn(1, 0, 0, 0, 0, 0); step(1);
    check("walk_l_act", 32'(action), 32'b1000001);
    check("walk_l_x", 32'(x_pos), 32'd108);
    set_btn(1, 1, 0, 0, 0, 0); step(1);
    check("lr_act", 32'(action), 32'b1100000);
    check("lr_x", 32'(x_pos), 32'd108);

    // left saturation
    do_reset();
    set_btn(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 60; i++) begin
      step(1);
      if (i == 49) check("sat_at50", 32'(x_pos), 32'd0);
    end
    check("sat_hold", 32'(x_pos), 32'd0);

    // punch held: one punch only
    set_btn(0, 0, 0, 0, 0, 1);
    m_hit_cnt = 0;
    for (int i = 0; i < 20; i++) begin step(1); step(0); end
    check("punch_hits", 32'(m_hit_cnt), 32'd1);
    check("punch_end", 32'(action[5:0]), 32'b100000);
    set_btn(0, 0, 0, 0, 0, 0); step(1);
    set_btn(0, 0, 0, 0, 0, 1); step(1);
    check("repunch", 32'(action[5:0]), 32'b010000);
    set_btn(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 10; i++) step(1);

    // jump to the right, then reset in the middle of another
    do_reset();
    set_btn(0, 1, 1, 0, 0, 0); step(1);
    for (int i = 0; i < JUMP_TICKS; i++) begin
      check("jump_busy", 32'(busy), 32'd1);
      step(1);
    end
    check("jump_x", 32'(x_pos), 32'd132);
    check("jump_end", 32'(action[5:0]), 32'b100000);
    set_btn(0, 1, 0, 0, 0, 0); step(1);
    set_btn(0, 1, 1, 0, 0, 0);
    for (int i = 0; i < 5; i++) step(1);
    do_reset();
    step(1);
    check("jump_after_rst", 32'(action[5:0]), 32'b001000);
    set_btn(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 20; i++) step(1);

    // priorities
    set_btn(0, 0, 1, 0, 0, 1); step(1);
    check("prio_punch", 32'(action[5:0]), 32'b010000);
    set_btn(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 10; i++) step(1);
    set_btn(0, 0, 0, 1, 1, 0); step(1);
    check("prio_shield", 32'(action[5:0]), 32'b000100);
    set_btn(0, 0, 0, 1, 0, 0); step(0);
    check("notick_hold", 32'(action[5:0]), 32'b000100);
    step(1);
    check("prio_crouch", 32'(action[5:0]), 32'b000010);

    // random traffic
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 7) == 0) btn_left   = $urandom_range(0, 1);
      if ($urandom_range(0, 7) == 0) btn_right  = $urandom_range(0, 1);
      if ($urandom_range(0, 15) == 0) btn_up    = $urandom_range(0, 1);
      if ($urandom_range(0, 15) == 0) btn_down  = $urandom_range(0, 1);
      if ($urandom_range(0, 15) == 0) btn_shield = $urandom_range(0, 1);
      if ($urandom_range(0, 15) == 0) btn_punch = $urandom_range(0, 1);
      if ($urandom_range(0, 799) == 0) do_reset();
      step($urandom_range(0, 2) != 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
